dmi_arbiter: RTL and testbench
==============================

Name: dmi_arbiter

Overview:
- Shares one Debug Module Interface (DMI) target between two requesters: port 0 is the JTAG DTM and port 1 is the host debug bridge.
- Sits between the requesters and the DMI passthrough tap in front of the Debug Module.
- Allows one transaction in flight. Uses round-robin grant, registered request and response, and a response timeout that returns an error to the owner.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in WAIT_RSP before a synthetic failure response is generated. Legal range 2..65535.
- CNT_W, 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- s0_req_valid / s1_req_valid  in  1  requester n has a request.
- s0_req_ready / s1_req_ready  out  1  request from requester n accepted this cycle.
- s0_req_addr / s1_req_addr  in  7  DMI address.
- s0_req_op / s1_req_op  in  2  DMI op: 0 nop, 1 read, 2 write.
- s0_req_data / s1_req_data  in  32  DMI write data.
- s0_rsp_valid / s1_rsp_valid  out  1  response to requester n is valid.
- s0_rsp_ready / s1_rsp_ready  in  1  requester n accepts the response.
- s0_rsp_resp / s1_rsp_resp  out  2  DMI response code: 0 ok, 2 failed, 3 busy.
- s0_rsp_data / s1_rsp_data  out  32  DMI read data.
- m_req_valid  out  1  request valid toward the DMI target.
- m_req_ready  in  1  target accepts the request.
- m_req_addr  out  7  registered request address.
- m_req_op  out  2  registered request op.
- m_req_data  out  32  registered request data.
- m_rsp_valid  in  1  target response valid.
- m_rsp_ready  out  1  arbiter accepts the target response.
- m_rsp_resp  in  2  target response code.
- m_rsp_data  in  32  target read data.
- owner  out  1  requester that owns the current transaction.
- busy  out  1  high whenever the state is not IDLE.
- stray_rsp  out  1  sticky flag: a target response arrived while in IDLE. Cleared only by reset.

Behaviour:
- Reset: state is IDLE and last_grant = 1, so port 0 wins the first tie.
  - All valid and ready outputs are 0 (exception: m_rsp_ready is 1 in IDLE, see below).
  - All address, op, data and resp outputs are 0; owner = 0, busy = 0, stray_rsp = 0.
- Reset asserted mid-transaction aborts it immediately. Nothing is replayed after reset is released.
- States: IDLE, ISSUE, WAIT_RSP, RETURN.
- IDLE:
  - Grant is combinational. If exactly one sn_req_valid is high, that port wins. If both are high, the port != last_grant wins.
  - sn_req_ready = 1 for the winner only. Readies never depend on m_* signals.
  - On the request handshake: register addr/op/data, set owner and last_grant to the winner, go to ISSUE.
  - m_rsp_ready = 1. Any m_rsp_valid here is consumed and dropped, and stray_rsp is set.
- ISSUE:
  - m_req_valid = 1 with the registered fields held stable.
  - On m_req_ready: clear the timeout counter, go to WAIT_RSP.
  - ISSUE has no timeout.
  - Latency: request handshake in cycle N gives m_req_valid high in cycle N+1.
- WAIT_RSP:
  - m_rsp_ready = 1 and the counter increments each cycle.
  - On m_rsp_valid: register resp and data, go to RETURN.
  - If the counter reaches TIMEOUT_CYCLES-1 with no response: register resp = 2 and data = 0, go to RETURN.
  - A response and the timeout in the same cycle: the real response wins.
  - A response arriving after a timeout is later dropped in IDLE and sets stray_rsp.
- RETURN:
  - s[owner]_rsp_valid = 1 with the registered resp and data; the other port's rsp_valid = 0.
  - m_rsp_ready = 0.
  - On s[owner]_rsp_ready: go to IDLE. A new grant can occur in the cycle after that.
- Op = 0 (nop) is forwarded unchanged. The arbiter does not interpret ops or the busy code 3; both pass through.
- Non-owner requests stay unaccepted (ready = 0) until the state returns to IDLE. No starvation: with both requesters valid, grants alternate.

Decomposition:
- Shared package dmi_pkg holds:
  - DMI_ADDR_W = 7, DMI_DATA_W = 32.
  - Op enum: NOP, READ, WRITE.
  - Resp enum: OK = 0, FAILED = 2, BUSY = 3.
  - Packed structs dmi_req_t {addr, op, data} and dmi_rsp_t {resp, data}.
  - State enum for the arbiter.
- One sub-module: dmi_rr_grant2, the 2-way round-robin grant with a last_grant register. Inputs: two valids and an advance strobe. Outputs: a one-hot grant.

Test Plan:
- Single request: s0 read, addr 0x11; target responds resp 0, data 0xDEADBEEF two cycles later → m_req_valid on the cycle after acceptance with addr 0x11, op 1; s0_rsp_valid with 0/0xDEADBEEF; s1 sees nothing.
- Contention: s0 and s1 both valid on the cycle after reset, holding requests continuously → grant order is s0, s1, s0, s1 over 4 transactions, with owner toggling 0, 1, 0, 1.
- Backpressure: m_req_ready held low for 5 cycles, then s1_rsp_ready held low for 3 cycles → the m_req fields stay stable; s1_rsp_valid and its data are held until accepted; s0 is not granted in the meantime.
- Timeout: TIMEOUT_CYCLES = 8 and the target never responds → s0 receives resp 2, data 0, 8 cycles after the m_req handshake; a late m_rsp_valid then sets stray_rsp = 1.
- Response coincident with timeout: m_rsp_valid with resp 0, data 0x5A in the final counting cycle → the owner receives 0/0x5A, and stray_rsp stays 0.
- Reset mid-operation: reset_n pulsed low during WAIT_RSP → every output returns to its reset value asynchronously; a later response sets stray_rsp, and new requests are served normally.

Source files
------------

// File: rtl/dmi_pkg.sv
// Shared DMI types for the arbiter: bus widths, op and response codes,
// request/response bundles and the arbiter state encoding.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    RSP_OK     = 2'd0,
    RSP_FAILED = 2'd2,
    RSP_BUSY   = 2'd3
  } dmi_resp_e;

  // Op and resp are kept as raw 2-bit fields so that codes the arbiter
  // does not interpret (including op 3) pass through untouched.
  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [1:0]            op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [1:0]            resp;
    logic [DMI_DATA_W-1:0] data;
  } dmi_rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RETURN   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/dmi_rr_grant2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// requester that did not win last time gets the grant.
module dmi_rr_grant2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_lastGrant;

  // Combinational one-hot grant from the two valids and the last winner
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = r_lastGrant ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end

  // Record the winner only when the grant is actually taken; starts at 1 so port 0 wins the first tie
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lastGrant <= 1'b1;
    end else if (i_advance && (|o_grant)) begin
      r_lastGrant <= o_grant[1];
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI target between the JTAG DTM (port 0) and the host debug
// bridge (port 1). One transaction in flight, round-robin grant, registered
// request/response, and a response timeout that returns FAILED to the owner.
module dmi_arbiter
  import dmi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  s0_req_valid,
  output logic                  s0_req_ready,
  input  logic [DMI_ADDR_W-1:0] s0_req_addr,
  input  logic [1:0]            s0_req_op,
  input  logic [DMI_DATA_W-1:0] s0_req_data,
  output logic                  s0_rsp_valid,
  input  logic                  s0_rsp_ready,
  output logic [1:0]            s0_rsp_resp,
  output logic [DMI_DATA_W-1:0] s0_rsp_data,
  input  logic                  s1_req_valid,
  output logic                  s1_req_ready,
  input  logic [DMI_ADDR_W-1:0] s1_req_addr,
  input  logic [1:0]            s1_req_op,
  input  logic [DMI_DATA_W-1:0] s1_req_data,
  output logic                  s1_rsp_valid,
  input  logic                  s1_rsp_ready,
  output logic [1:0]            s1_rsp_resp,
  output logic [DMI_DATA_W-1:0] s1_rsp_data,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [DMI_ADDR_W-1:0] m_req_addr,
  output logic [1:0]            m_req_op,
  output logic [DMI_DATA_W-1:0] m_req_data,
  input  logic                  m_rsp_valid,
  output logic                  m_rsp_ready,
  input  logic [1:0]            m_rsp_resp,
  input  logic [DMI_DATA_W-1:0] m_rsp_data,
  output logic                  owner,
  output logic                  busy,
  output logic                  stray_rsp
);

  localparam logic [CNT_W-1:0] LP_LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       r_state;
  dmi_req_t         r_req;
  dmi_rsp_t         r_rsp;
  logic             r_owner;
  logic [CNT_W-1:0] r_count;
  logic             r_strayRsp;

  logic [1:0] w_grant;
  logic       w_isIdle;
  logic       w_reqFire;
  logic       w_ownerRspReady;
  dmi_req_t   w_req0;
  dmi_req_t   w_req1;

  assign w_isIdle  = (r_state == ST_IDLE);
  assign w_reqFire = w_isIdle && (|w_grant);
  assign w_req0    = '{addr: s0_req_addr, op: s0_req_op, data: s0_req_data};
  assign w_req1    = '{addr: s1_req_addr, op: s1_req_op, data: s1_req_data};
  assign w_ownerRspReady = r_owner ? s1_rsp_ready : s0_rsp_ready;

  dmi_rr_grant2 u_grant (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_valid0 (s0_req_valid),
    .i_valid1 (s1_req_valid),
    .i_advance(w_isIdle),
    .o_grant  (w_grant)
  );

  // Request readies depend only on state and grant, never on the target side
  assign s0_req_ready = w_isIdle && w_grant[0];
  assign s1_req_ready = w_isIdle && w_grant[1];

  assign m_req_valid = (r_state == ST_ISSUE);
  assign m_req_addr  = r_req.addr;
  assign m_req_op    = r_req.op;
  assign m_req_data  = r_req.data;
  assign m_rsp_ready = w_isIdle || (r_state == ST_WAIT_RSP);

  assign s0_rsp_valid = (r_state == ST_RETURN) && !r_owner;
  assign s1_rsp_valid = (r_state == ST_RETURN) && r_owner;
  assign s0_rsp_resp  = r_rsp.resp;
  assign s0_rsp_data  = r_rsp.data;
  assign s1_rsp_resp  = r_rsp.resp;
  assign s1_rsp_data  = r_rsp.data;

  assign owner     = r_owner;
  assign busy      = !w_isIdle;
  assign stray_rsp = r_strayRsp;

  // Transaction FSM: capture request, issue it, wait (bounded) for the response, hand it back
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_req      <= '0;
      r_rsp      <= '0;
      r_owner    <= 1'b0;
      r_count    <= '0;
      r_strayRsp <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m_rsp_valid) begin
            r_strayRsp <= 1'b1;
          end
          if (w_reqFire) begin
            r_req   <= w_grant[1] ? w_req1 : w_req0;
            r_owner <= w_grant[1];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_req_ready) begin
            r_count <= '0;
            r_state <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (m_rsp_valid) begin
            r_rsp   <= '{resp: m_rsp_resp, data: m_rsp_data};
            r_state <= ST_RETURN;
          end else if (r_count == LP_LAST_COUNT) begin
            r_rsp   <= '{resp: RSP_FAILED, data: '0};
            r_state <= ST_RETURN;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        ST_RETURN: begin
          if (w_ownerRspReady) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter with a short timeout so the timeout paths
// are reachable in a few cycles.
module tb_dmi_arbiter;

  logic        clock;
  logic        reset_n;
  logic        s0_req_valid, s0_req_ready, s0_rsp_valid, s0_rsp_ready;
  logic [6:0]  s0_req_addr;
  logic [1:0]  s0_req_op, s0_rsp_resp;
  logic [31:0] s0_req_data, s0_rsp_data;
  logic        s1_req_valid, s1_req_ready, s1_rsp_valid, s1_rsp_ready;
  logic [6:0]  s1_req_addr;
  logic [1:0]  s1_req_op, s1_rsp_resp;
  logic [31:0] s1_req_data, s1_rsp_data;
  logic        m_req_valid, m_req_ready, m_rsp_valid, m_rsp_ready;
  logic [6:0]  m_req_addr;
  logic [1:0]  m_req_op, m_rsp_resp;
  logic [31:0] m_req_data, m_rsp_data;
  logic        owner, busy, stray_rsp;

  int errCount = 0;
  int checkCount = 0;

  dmi_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_addr(s0_req_addr),
    .s0_req_op(s0_req_op), .s0_req_data(s0_req_data), .s0_rsp_valid(s0_rsp_valid),
    .s0_rsp_ready(s0_rsp_ready), .s0_rsp_resp(s0_rsp_resp), .s0_rsp_data(s0_rsp_data),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_addr(s1_req_addr),
    .s1_req_op(s1_req_op), .s1_req_data(s1_req_data), .s1_rsp_valid(s1_rsp_valid),
    .s1_rsp_ready(s1_rsp_ready), .s1_rsp_resp(s1_rsp_resp), .s1_rsp_data(s1_rsp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_op(m_req_op), .m_req_data(m_req_data), .m_rsp_valid(m_rsp_valid),
    .m_rsp_ready(m_rsp_ready), .m_rsp_resp(m_rsp_resp), .m_rsp_data(m_rsp_data),
    .owner(owner), .busy(busy), .stray_rsp(stray_rsp)
  );

  // Free-running clock, period 10
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a fault leaves the bench waiting forever
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    s0_req_valid = 0; s0_req_addr = '0; s0_req_op = '0; s0_req_data = '0; s0_rsp_ready = 0;
    s1_req_valid = 0; s1_req_addr = '0; s1_req_op = '0; s1_req_data = '0; s1_rsp_ready = 0;
    m_req_ready = 0; m_rsp_valid = 0; m_rsp_resp = '0; m_rsp_data = '0;
  endtask

  task automatic pulseReset();
    clearInputs();
    @(posedge clock);
    #3 reset_n = 0;
    #4 reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clearInputs();
    reset_n = 0;
    #12;
    checkCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    checkCount++; if (m_req_valid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_m_req_valid: got %0h expected 0", m_req_valid); end
    checkCount++; if (m_rsp_ready !== 1'b1) begin errCount++; $display("[TB] FAIL reset_m_rsp_ready: got %0h expected 1", m_rsp_ready); end
    checkCount++; if ({s0_req_ready, s1_req_ready, s0_rsp_valid, s1_rsp_valid} !== 4'b0) begin errCount++; $display("[TB] FAIL reset_handshakes: got %0h expected 0", {s0_req_ready, s1_req_ready, s0_rsp_valid, s1_rsp_valid}); end
    checkCount++; if ({m_req_addr, m_req_op, m_req_data} !== 41'h0) begin errCount++; $display("[TB] FAIL reset_m_req_fields: got %0h expected 0", {m_req_addr, m_req_op, m_req_data}); end
    checkCount++; if ({owner, stray_rsp, s0_rsp_resp, s0_rsp_data} !== 36'h0) begin errCount++; $display("[TB] FAIL reset_misc: got %0h expected 0", {owner, stray_rsp, s0_rsp_resp, s0_rsp_data}); end
    @(posedge clock); #1 reset_n = 1;
    tick();
    checkCount++; if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL reset_release_busy: got %0h expected 0", busy); end
  endtask

  task automatic test_single();
    s0_req_valid = 1; s0_req_addr = 7'h11; s0_req_op = 2'd1; s0_req_data = 32'h0;
    #1;
    checkCount++; if ({s1_req_ready, s0_req_ready} !== 2'b01) begin errCount++; $display("[TB] FAIL single_grant: got %0b expected 01", {s1_req_ready, s0_req_ready}); end
    tick();
    s0_req_valid = 0;
    #1;
    checkCount++; if ({m_req_valid, m_req_addr, m_req_op} !== {1'b1, 7'h11, 2'd1}) begin errCount++; $display("[TB] FAIL single_m_req: got %0h expected %0h", {m_req_valid, m_req_addr, m_req_op}, {1'b1, 7'h11, 2'd1}); end
    checkCount++; if ({owner, busy} !== 2'b01) begin errCount++; $display("[TB] FAIL single_owner_busy: got %0b expected 01", {owner, busy}); end
    m_req_ready = 1;
    tick();
    m_req_ready = 0;
    tick();
    m_rsp_valid = 1; m_rsp_resp = 2'd0; m_rsp_data = 32'hDEADBEEF;
    #1;
    checkCount++; if (m_rsp_ready !== 1'b1) begin errCount++; $display("[TB] FAIL single_m_rsp_ready: got %0h expected 1", m_rsp_ready); end
    tick();
    m_rsp_valid = 0;
    #1;
    checkCount++; if ({s0_rsp_valid, s0_rsp_resp, s0_rsp_data} !== {1'b1, 2'd0, 32'hDEADBEEF}) begin errCount++; $display("[TB] FAIL single_s0_rsp: got %0h expected %0h", {s0_rsp_valid, s0_rsp_resp, s0_rsp_data}, {1'b1, 2'd0, 32'hDEADBEEF}); end
    checkCount++; if ({s1_rsp_valid, m_rsp_ready} !== 2'b00) begin errCount++; $display("[TB] FAIL single_s1_quiet: got %0b expected 00", {s1_rsp_valid, m_rsp_ready}); end
    s0_rsp_ready = 1;
    tick();
    s0_rsp_ready = 0;
    #1;
    checkCount++; if ({busy, s0_rsp_valid} !== 2'b00) begin errCount++; $display("[TB] FAIL single_done: got %0b expected 00", {busy, s0_rsp_valid}); end
  endtask

  task automatic test_contention();
    bit expSeq [4];
    expSeq = '{1'b0, 1'b1, 1'b0, 1'b1};
    pulseReset();
    s0_req_valid = 1; s0_req_addr = 7'h20; s0_req_op = 2'd1; s0_req_data = 32'hA0;
    s1_req_valid = 1; s1_req_addr = 7'h30; s1_req_op = 2'd2; s1_req_data = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkCount++; if ({s1_req_ready, s0_req_ready} !== (expSeq[i] ? 2'b10 : 2'b01)) begin errCount++; $display("[TB] FAIL contention_ready[%0d]: got %0b expected %0b", i, {s1_req_ready, s0_req_ready}, (expSeq[i] ? 2'b10 : 2'b01)); end
      tick();
      checkCount++; if ({owner, m_req_addr} !== {expSeq[i], (expSeq[i] ? 7'h30 : 7'h20)}) begin errCount++; $display("[TB] FAIL contention_owner[%0d]: got %0h expected %0h", i, {owner, m_req_addr}, {expSeq[i], (expSeq[i] ? 7'h30 : 7'h20)}); end
      checkCount++; if ({s1_req_ready, s0_req_ready} !== 2'b00) begin errCount++; $display("[TB] FAIL contention_blocked[%0d]: got %0b expected 00", i, {s1_req_ready, s0_req_ready}); end
      m_req_ready = 1;
      tick();
      m_req_ready = 0;
      m_rsp_valid = 1; m_rsp_resp = 2'd0; m_rsp_data = 32'h100 + i;
      tick();
      m_rsp_valid = 0;
      #1;
      checkCount++; if ({s1_rsp_valid, s0_rsp_valid, s0_rsp_data} !== {(expSeq[i] ? 2'b10 : 2'b01), 32'h100 + i}) begin errCount++; $display("[TB] FAIL contention_rsp[%0d]: got %0h expected %0h", i, {s1_rsp_valid, s0_rsp_valid, s0_rsp_data}, {(expSeq[i] ? 2'b10 : 2'b01), 32'h100 + i}); end
      s0_rsp_ready = 1; s1_rsp_ready = 1;
      tick();
      s0_rsp_ready = 0; s1_rsp_ready = 0;
    end
    s0_req_valid = 0; s1_req_valid = 0;
  endtask

  task automatic test_backpressure();
    s1_req_valid = 1; s1_req_addr = 7'h42; s1_req_op = 2'd2; s1_req_data = 32'h12345678;
    tick();
    s1_req_valid = 0;
    s0_req_valid = 1; s0_req_addr = 7'h01; s0_req_op = 2'd1; s0_req_data = 32'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkCount++; if ({m_req_valid, m_req_addr, m_req_op, m_req_data} !== {1'b1, 7'h42, 2'd2, 32'h12345678}) begin errCount++; $display("[TB] FAIL bp_m_req_hold[%0d]: got %0h expected %0h", c, {m_req_valid, m_req_addr, m_req_op, m_req_data}, {1'b1, 7'h42, 2'd2, 32'h12345678}); end
      checkCount++; if (s0_req_ready !== 1'b0) begin errCount++; $display("[TB] FAIL bp_s0_blocked_issue[%0d]: got %0h expected 0", c, s0_req_ready); end
      tick();
    end
    m_req_ready = 1;
    tick();
    m_req_ready = 0;
    m_rsp_valid = 1; m_rsp_resp = 2'd3; m_rsp_data = 32'hCAFEF00D;
    tick();
    m_rsp_valid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkCount++; if ({s1_rsp_valid, s1_rsp_resp, s1_rsp_data} !== {1'b1, 2'd3, 32'hCAFEF00D}) begin errCount++; $display("[TB] FAIL bp_s1_rsp_hold[%0d]: got %0h expected %0h", c, {s1_rsp_valid, s1_rsp_resp, s1_rsp_data}, {1'b1, 2'd3, 32'hCAFEF00D}); end
      checkCount++; if ({s0_req_ready, s0_rsp_valid} !== 2'b00) begin errCount++; $display("[TB] FAIL bp_s0_blocked_return[%0d]: got %0b expected 00", c, {s0_req_ready, s0_rsp_valid}); end
      tick();
    end
    s1_rsp_ready = 1;
    tick();
    s1_rsp_ready = 0;
    #1;
    checkCount++; if ({busy, s0_req_ready} !== 2'b01) begin errCount++; $display("[TB] FAIL bp_s0_after: got %0b expected 01", {busy, s0_req_ready}); end
    s0_req_valid = 0;
  endtask

  task automatic test_timeout();
    tick();
    s0_req_valid = 1; s0_req_addr = 7'h05; s0_req_op = 2'd1; s0_req_data = 32'h0;
    tick();
    s0_req_valid = 0;
    m_req_ready = 1;
    tick();
    m_req_ready = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkCount++; if (s0_rsp_valid !== (k == 8)) begin errCount++; $display("[TB] FAIL timeout_valid_at_%0d: got %0h expected %0h", k, s0_rsp_valid, (k == 8)); end
    end
    checkCount++; if ({s0_rsp_resp, s0_rsp_data, stray_rsp} !== {2'd2, 32'h0, 1'b0}) begin errCount++; $display("[TB] FAIL timeout_rsp: got %0h expected %0h", {s0_rsp_resp, s0_rsp_data, stray_rsp}, {2'd2, 32'h0, 1'b0}); end
    s0_rsp_ready = 1;
    tick();
    s0_rsp_ready = 0;
    m_rsp_valid = 1; m_rsp_resp = 2'd0; m_rsp_data = 32'h99;
    #1;
    checkCount++; if (m_rsp_ready !== 1'b1) begin errCount++; $display("[TB] FAIL late_m_rsp_ready: got %0h expected 1", m_rsp_ready); end
    tick();
    m_rsp_valid = 0;
    checkCount++; if ({stray_rsp, busy} !== 2'b10) begin errCount++; $display("[TB] FAIL late_stray: got %0b expected 10", {stray_rsp, busy}); end
  endtask

  task automatic test_coincident();
    pulseReset();
    s1_req_valid = 1; s1_req_addr = 7'h33; s1_req_op = 2'd1; s1_req_data = 32'h0;
    tick();
    s1_req_valid = 0;
    m_req_ready = 1;
    tick();
    m_req_ready = 0;
    repeat (7) tick();
    m_rsp_valid = 1; m_rsp_resp = 2'd0; m_rsp_data = 32'h5A;
    tick();
    m_rsp_valid = 0;
    checkCount++; if ({s1_rsp_valid, s1_rsp_resp, s1_rsp_data} !== {1'b1, 2'd0, 32'h5A}) begin errCount++; $display("[TB] FAIL coincident_rsp: got %0h expected %0h", {s1_rsp_valid, s1_rsp_resp, s1_rsp_data}, {1'b1, 2'd0, 32'h5A}); end
    s1_rsp_ready = 1;
    tick();
    s1_rsp_ready = 0;
    tick();
    checkCount++; if ({stray_rsp, busy} !== 2'b00) begin errCount++; $display("[TB] FAIL coincident_no_stray: got %0b expected 00", {stray_rsp, busy}); end
  endtask

  task automatic test_reset_mid();
    s1_req_valid = 1; s1_req_addr = 7'h6C; s1_req_op = 2'd2; s1_req_data = 32'hFEED;
    tick();
    s1_req_valid = 0;
    m_req_ready = 1;
    tick();
    m_req_ready = 0;
    tick();
    #2 reset_n = 0;
    #1;
    checkCount++; if ({busy, owner, m_req_valid, m_req_addr, m_req_data} !== 42'h0) begin errCount++; $display("[TB] FAIL midreset_outputs: got %0h expected 0", {busy, owner, m_req_valid, m_req_addr, m_req_data}); end
    checkCount++; if ({m_rsp_ready, s1_rsp_valid, stray_rsp} !== 3'b100) begin errCount++; $display("[TB] FAIL midreset_rsp_side: got %0b expected 100", {m_rsp_ready, s1_rsp_valid, stray_rsp}); end
    #2 reset_n = 1;
    tick();
    checkCount++; if ({busy, m_req_valid} !== 2'b00) begin errCount++; $display("[TB] FAIL midreset_no_replay: got %0b expected 00", {busy, m_req_valid}); end
    m_rsp_valid = 1; m_rsp_resp = 2'd0; m_rsp_data = 32'h1;
    tick();
    m_rsp_valid = 0;
    checkCount++; if (stray_rsp !== 1'b1) begin errCount++; $display("[TB] FAIL midreset_stray: got %0h expected 1", stray_rsp); end
    s0_req_valid = 1; s0_req_addr = 7'h7F; s0_req_op = 2'd0; s0_req_data = 32'h55;
    #1;
    checkCount++; if (s0_req_ready !== 1'b1) begin errCount++; $display("[TB] FAIL midreset_new_grant: got %0h expected 1", s0_req_ready); end
    tick();
    s0_req_valid = 0;
    checkCount++; if ({owner, m_req_valid, m_req_addr, m_req_op, m_req_data} !== {1'b0, 1'b1, 7'h7F, 2'd0, 32'h55}) begin errCount++; $display("[TB] FAIL midreset_nop_issue: got %0h expected %0h", {owner, m_req_valid, m_req_addr, m_req_op, m_req_data}, {1'b0, 1'b1, 7'h7F, 2'd0, 32'h55}); end
    m_req_ready = 1;
    tick();
    m_req_ready = 0;
    m_rsp_valid = 1; m_rsp_resp = 2'd0; m_rsp_data = 32'h77;
    tick();
    m_rsp_valid = 0;
    checkCount++; if ({s0_rsp_valid, s0_rsp_data} !== {1'b1, 32'h77}) begin errCount++; $display("[TB] FAIL midreset_new_rsp: got %0h expected %0h", {s0_rsp_valid, s0_rsp_data}, {1'b1, 32'h77}); end
    s0_rsp_ready = 1;
    tick();
    s0_rsp_ready = 0;
  endtask

  // Run every scenario in order, then report
  initial begin
    $display("[TB] starting dmi_arbiter bench");
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_coincident();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
